// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with two selectable timing sets.
// Counters advance on pixel strobes; all outputs are registered and decoded
// from the next-state position so they line up with the counters exactly.
module vga_timing_gen #(
  parameter int unsigned H_ACT_A  = 640,
  parameter int unsigned H_FP_A   = 16,
  parameter int unsigned H_SW_A   = 96,
  parameter int unsigned H_BP_A   = 48,
  parameter int unsigned V_ACT_A  = 480,
  parameter int unsigned V_FP_A   = 10,
  parameter int unsigned V_SW_A   = 2,
  parameter int unsigned V_BP_A   = 33,
  parameter logic        HS_POL_A = 1'b0,
  parameter logic        VS_POL_A = 1'b0,
  parameter int unsigned H_ACT_B  = 640,
  parameter int unsigned H_FP_B   = 16,
  parameter int unsigned H_SW_B   = 96,
  parameter int unsigned H_BP_B   = 48,
  parameter int unsigned V_ACT_B  = 400,
  parameter int unsigned V_FP_B   = 12,
  parameter int unsigned V_SW_B   = 2,
  parameter int unsigned V_BP_B   = 35,
  parameter logic        HS_POL_B = 1'b0,
  parameter logic        VS_POL_B = 1'b1,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_mode,
  output logic               o_mode,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_blanking,
  output logic               o_active,
  output logic               o_screenend,
  output logic               o_animate,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int unsigned H_TOT_A = H_FP_A + H_SW_A + H_BP_A + H_ACT_A;
  localparam int unsigned V_TOT_A = V_ACT_A + V_FP_A + V_SW_A + V_BP_A;
  localparam int unsigned H_TOT_B = H_FP_B + H_SW_B + H_BP_B + H_ACT_B;
  localparam int unsigned V_TOT_B = V_ACT_B + V_FP_B + V_SW_B + V_BP_B;

  // Region boundaries per set, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] H_LAST_A  = CNT_W'(H_TOT_A - 1);
  localparam logic [CNT_W-1:0] H_SS_A    = CNT_W'(H_FP_A);
  localparam logic [CNT_W-1:0] H_SE_A    = CNT_W'(H_FP_A + H_SW_A);
  localparam logic [CNT_W-1:0] H_AS_A    = CNT_W'(H_FP_A + H_SW_A + H_BP_A);
  localparam logic [CNT_W-1:0] V_LAST_A  = CNT_W'(V_TOT_A - 1);
  localparam logic [CNT_W-1:0] V_ACT_N_A = CNT_W'(V_ACT_A);
  localparam logic [CNT_W-1:0] V_ALST_A  = CNT_W'(V_ACT_A - 1);
  localparam logic [CNT_W-1:0] V_SS_A    = CNT_W'(V_ACT_A + V_FP_A);
  localparam logic [CNT_W-1:0] V_SE_A    = CNT_W'(V_ACT_A + V_FP_A + V_SW_A);
  localparam logic [Y_W-1:0]   Y_CLMP_A  = Y_W'(V_ACT_A - 1);

  localparam logic [CNT_W-1:0] H_LAST_B  = CNT_W'(H_TOT_B - 1);
  localparam logic [CNT_W-1:0] H_SS_B    = CNT_W'(H_FP_B);
  localparam logic [CNT_W-1:0] H_SE_B    = CNT_W'(H_FP_B + H_SW_B);
  localparam logic [CNT_W-1:0] H_AS_B    = CNT_W'(H_FP_B + H_SW_B + H_BP_B);
  localparam logic [CNT_W-1:0] V_LAST_B  = CNT_W'(V_TOT_B - 1);
  localparam logic [CNT_W-1:0] V_ACT_N_B = CNT_W'(V_ACT_B);
  localparam logic [CNT_W-1:0] V_ALST_B  = CNT_W'(V_ACT_B - 1);
  localparam logic [CNT_W-1:0] V_SS_B    = CNT_W'(V_ACT_B + V_FP_B);
  localparam logic [CNT_W-1:0] V_SE_B    = CNT_W'(V_ACT_B + V_FP_B + V_SW_B);
  localparam logic [Y_W-1:0]   Y_CLMP_B  = Y_W'(V_ACT_B - 1);

  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic               mode_q, mode_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic [CNT_W-1:0] cnt_h_last, cnt_v_last;
  logic [CNT_W-1:0] s_h_last, s_h_ss, s_h_se, s_h_as;
  logic [CNT_W-1:0] s_v_last, s_v_act, s_v_alst, s_v_ss, s_v_se;
  logic [Y_W-1:0]   s_y_clmp;
  logic             s_hs_pol, s_vs_pol;

  logic             hs_d, vs_d, active_d, screenend_d, animate_d, h_in_act, v_in_act;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;

  logic             hs_q, vs_q, active_q, screenend_q, animate_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;

  // Next counter/mode/frame state; the mode only switches at the frame wrap.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    mode_d     = mode_q;
    frame_d    = frame_q;
    cnt_h_last = mode_q ? H_LAST_B : H_LAST_A;
    cnt_v_last = mode_q ? V_LAST_B : V_LAST_A;
    if (i_pix_stb) begin
      if (h_q == cnt_h_last) begin
        h_d = '0;
        if (v_q == cnt_v_last) begin
          v_d     = '0;
          mode_d  = i_mode;
          frame_d = frame_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Output decode of the next position, using the set that will be in force.
  always_comb begin
    s_h_last = mode_d ? H_LAST_B  : H_LAST_A;
    s_h_ss   = mode_d ? H_SS_B    : H_SS_A;
    s_h_se   = mode_d ? H_SE_B    : H_SE_A;
    s_h_as   = mode_d ? H_AS_B    : H_AS_A;
    s_v_last = mode_d ? V_LAST_B  : V_LAST_A;
    s_v_act  = mode_d ? V_ACT_N_B : V_ACT_N_A;
    s_v_alst = mode_d ? V_ALST_B  : V_ALST_A;
    s_v_ss   = mode_d ? V_SS_B    : V_SS_A;
    s_v_se   = mode_d ? V_SE_B    : V_SE_A;
    s_y_clmp = mode_d ? Y_CLMP_B  : Y_CLMP_A;
    s_hs_pol = mode_d ? HS_POL_B  : HS_POL_A;
    s_vs_pol = mode_d ? VS_POL_B  : VS_POL_A;

    h_in_act    = (h_d >= s_h_as);
    v_in_act    = (v_d < s_v_act);
    hs_d        = (h_d >= s_h_ss && h_d < s_h_se) ? s_hs_pol : ~s_hs_pol;
    vs_d        = (v_d >= s_v_ss && v_d < s_v_se) ? s_vs_pol : ~s_vs_pol;
    active_d    = h_in_act && v_in_act;
    x_d         = h_in_act ? X_W'(h_d - s_h_as) : '0;
    y_d         = v_in_act ? Y_W'(v_d) : s_y_clmp;
    screenend_d = (h_d == s_h_last) && (v_d == s_v_last);
    animate_d   = (h_d == s_h_last) && (v_d == s_v_alst);
  end

  // State and output registers; with no strobe the decode reproduces the held state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= 1'b0;
      frame_q     <= '0;
      hs_q        <= ~HS_POL_A;
      vs_q        <= ~VS_POL_A;
      active_q    <= 1'b0;
      screenend_q <= 1'b0;
      animate_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      frame_q     <= frame_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      active_q    <= active_d;
      screenend_q <= screenend_d;
      animate_q   <= animate_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign o_mode      = mode_q;
  assign o_frame     = frame_q;
  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_active    = active_q;
  assign o_blanking  = ~active_q;
  assign o_screenend = screenend_q;
  assign o_animate   = animate_q;
  assign o_x         = x_q;
  assign o_y         = y_q;

endmodule
